// File: rtl/pc8001_video_pkg.sv
// Shared geometry and CPU-port state encoding for the 80x25 text video path.
package pc8001_video_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_OFFSET = 40;
   localparam int V_ACTIVE = 400;
   localparam int COLS     = 80;
   localparam int CHAR_H   = 16;
   localparam int CHAR_SH  = $clog2(CHAR_H);
   localparam int HMAX     = 800;
   localparam int VMAX     = 525;

   localparam logic [11:0] VRAM_BASE = 12'h000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CPU1 = 2'd1,
      S_CPU2 = 2'd2,
      S_ACK  = 2'd3
   } cpu_state_t;

endpackage

// File: rtl/vram_addr_gen.sv
// Combinational display-slot decode: flags the first pixel of each active cell
// and produces that cell's VRAM address and font line.
module vram_addr_gen
   import pc8001_video_pkg::*;
(
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   output logic        active,
   output logic [11:0] addr,
   output logic [3:0]  line
);

   logic [9:0]  win_line;
   logic [11:0] row;
   logic [11:0] col;

   always_comb begin
      win_line = v_cnt - 10'(V_OFFSET);
      row      = 12'(win_line >> CHAR_SH);
      col      = {5'd0, h_cnt[9:3]};
      line     = 4'(win_line & 10'(CHAR_H - 1));
      // row*80 as two shifts keeps this adder-only
      addr     = VRAM_BASE + (row << 6) + (row << 4) + col;
      active   = (h_cnt[2:0] == 3'd0)
               && (h_cnt < 10'(H_ACTIVE))
               && (v_cnt >= 10'(V_OFFSET))
               && (v_cnt < 10'(V_OFFSET + V_ACTIVE));
   end

endmodule

// File: rtl/vram_fetch_arbiter.sv
// Shares the text VRAM between display fetch (priority, fixed 2-edge latency to code)
// and CPU REQ/ACK accesses (ACK 3 edges after grant-sample, 4 if deferred by a fetch).
module vram_fetch_arbiter
   import pc8001_video_pkg::*;
(
   input  logic        I_CLK,
   input  logic        I_RST,
   input  logic [9:0]  I_H_CNT,
   input  logic [9:0]  I_V_CNT,
   input  logic        I_CPU_REQ,
   input  logic        I_CPU_WE,
   input  logic [11:0] I_CPU_ADDR,
   input  logic [7:0]  I_CPU_WDATA,
   output logic        O_CPU_ACK,
   output logic [7:0]  O_CPU_RDATA,
   output logic [11:0] O_RAM_ADDR,
   output logic        O_RAM_WE,
   output logic [7:0]  O_RAM_WDATA,
   input  logic [7:0]  I_RAM_RDATA,
   output logic [7:0]  O_CHR_CODE,
   output logic [3:0]  O_CHR_LINE,
   output logic        O_CHR_VALID
);

   cpu_state_t  state;
   logic        ds;
   logic [11:0] ds_addr;
   logic [3:0]  ds_line;
   logic        s1_vld, s2_vld;
   logic [3:0]  s1_line, s2_line;

   vram_addr_gen u_addr_gen (
      .h_cnt  (I_H_CNT),
      .v_cnt  (I_V_CNT),
      .active (ds),
      .addr   (ds_addr),
      .line   (ds_line)
   );

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state       <= S_IDLE;
         O_CPU_ACK   <= 1'b0;
         O_CPU_RDATA <= 8'd0;
         O_RAM_ADDR  <= 12'd0;
         O_RAM_WE    <= 1'b0;
         O_RAM_WDATA <= 8'd0;
         O_CHR_CODE  <= 8'd0;
         O_CHR_LINE  <= 4'd0;
         O_CHR_VALID <= 1'b0;
         s1_vld      <= 1'b0;
         s2_vld      <= 1'b0;
         s1_line     <= 4'd0;
         s2_line     <= 4'd0;
      end else begin
         O_RAM_WE <= 1'b0;
         s1_vld   <= ds;
         s2_vld   <= s1_vld;
         s2_line  <= s1_line;
         if (ds) begin
            O_RAM_ADDR <= ds_addr;
            s1_line    <= ds_line;
         end
         // Code lands two edges after its slot; an empty slot clears valid at phase 2
         if (s2_vld) begin
            O_CHR_CODE  <= I_RAM_RDATA;
            O_CHR_LINE  <= s2_line;
            O_CHR_VALID <= 1'b1;
         end else if (I_H_CNT[2:0] == 3'd2) begin
            O_CHR_VALID <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (I_CPU_REQ && !ds) begin
                  O_RAM_ADDR  <= I_CPU_ADDR;
                  O_RAM_WE    <= I_CPU_WE;
                  O_RAM_WDATA <= I_CPU_WDATA;
                  state       <= S_CPU1;
               end
            end
            S_CPU1: state <= S_CPU2;
            S_CPU2: begin
               if (!I_CPU_WE) O_CPU_RDATA <= I_RAM_RDATA;
               O_CPU_ACK <= 1'b1;
               state     <= S_ACK;
            end
            S_ACK: begin
               O_CPU_ACK <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed bench for vram_fetch_arbiter with an edge-scheduled reference model and VRAM.
module tb_vram_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  h_cnt = 10'd0;
   logic [9:0]  v_cnt = 10'd0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [11:0] cpu_addr = 12'd0;
   logic [7:0]  cpu_wdata = 8'd0;
   logic        O_CPU_ACK, O_RAM_WE, O_CHR_VALID;
   logic [7:0]  O_CPU_RDATA, O_RAM_WDATA, O_CHR_CODE;
   logic [11:0] O_RAM_ADDR;
   logic [3:0]  O_CHR_LINE;
   logic [7:0]  ram_rdata = 8'd0;
   logic [7:0]  mem [0:4095];
   logic        fill = 1'b1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   vram_fetch_arbiter dut (
      .I_CLK       (clk),
      .I_RST       (rst),
      .I_H_CNT     (h_cnt),
      .I_V_CNT     (v_cnt),
      .I_CPU_REQ   (cpu_req),
      .I_CPU_WE    (cpu_we),
      .I_CPU_ADDR  (cpu_addr),
      .I_CPU_WDATA (cpu_wdata),
      .O_CPU_ACK   (O_CPU_ACK),
      .O_CPU_RDATA (O_CPU_RDATA),
      .O_RAM_ADDR  (O_RAM_ADDR),
      .O_RAM_WE    (O_RAM_WE),
      .O_RAM_WDATA (O_RAM_WDATA),
      .I_RAM_RDATA (ram_rdata),
      .O_CHR_CODE  (O_CHR_CODE),
      .O_CHR_LINE  (O_CHR_LINE),
      .O_CHR_VALID (O_CHR_VALID)
   );

   // Synchronous single-port VRAM; contents start as (addr*7+3) mod 256
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'(i * 7 + 3);
      end else if (O_RAM_WE) begin
         mem[O_RAM_ADDR] <= O_RAM_WDATA;
      end
      ram_rdata <= mem[O_RAM_ADDR];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: expected outputs after each edge, from sampled counters and CPU inputs
   logic [11:0] e_addr;
   logic        e_we, e_ack, e_vld;
   logic [7:0]  e_wdata, e_rdata, e_code;
   logic [3:0]  e_line;
   int          k = 4;
   int          g = -1;
   logic        m_we;
   logic [11:0] m_addr;
   logic [7:0]  m_rd;
   logic        fv [4];
   logic [11:0] fa [4];
   logic [3:0]  fl [4];
   logic [7:0]  fd [4];
   int          mh, mv, ma;
   logic        mds;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            e_addr = 12'd0; e_we = 1'b0; e_wdata = 8'd0; e_ack = 1'b0;
            e_rdata = 8'd0; e_code = 8'd0; e_line = 4'd0; e_vld = 1'b0;
            g = -1;
            for (int j = 0; j < 4; j++) fv[j] = 1'b0;
         end
         chk("ram_addr",  32'(O_RAM_ADDR),  32'(e_addr));
         chk("ram_we",    32'(O_RAM_WE),    32'(e_we));
         chk("ram_wdata", 32'(O_RAM_WDATA), 32'(e_wdata));
         chk("cpu_ack",   32'(O_CPU_ACK),   32'(e_ack));
         chk("cpu_rdata", 32'(O_CPU_RDATA), 32'(e_rdata));
         chk("chr_code",  32'(O_CHR_CODE),  32'(e_code));
         chk("chr_line",  32'(O_CHR_LINE),  32'(e_line));
         chk("chr_valid", 32'(O_CHR_VALID), 32'(e_vld));
         k++;
         if (!rst) begin
            mh  = int'(h_cnt);
            mv  = int'(v_cnt);
            mds = (mh % 8 == 0) && (mh < 640) && (mv >= 40) && (mv < 440);
            e_we = 1'b0;
            if (fv[(k - 1) & 3]) fd[(k - 1) & 3] = mem[fa[(k - 1) & 3]];
            if (fv[(k - 2) & 3]) begin
               e_code = fd[(k - 2) & 3];
               e_line = fl[(k - 2) & 3];
               e_vld  = 1'b1;
               fv[(k - 2) & 3] = 1'b0;
            end else if (mh % 8 == 2) begin
               e_vld = 1'b0;
            end
            fv[k & 3] = mds;
            if (mds) begin
               ma = ((mv - 40) / 16) * 80 + mh / 8;
               e_addr = 12'(ma);
               fa[k & 3] = 12'(ma);
               fl[k & 3] = 4'((mv - 40) % 16);
            end
            e_ack = (g >= 0) && (k == g + 2);
            if (g >= 0 && k == g + 1) m_rd = mem[m_addr];
            if (e_ack && !m_we) e_rdata = m_rd;
            if (!(g >= 0 && k <= g + 3) && cpu_req && !mds) begin
               g = k; m_we = cpu_we; m_addr = cpu_addr;
               e_addr = cpu_addr; e_we = cpu_we; e_wdata = cpu_wdata;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (h_cnt == 10'd799) begin
         h_cnt = 10'd0;
         v_cnt = (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
      end else begin
         h_cnt = h_cnt + 10'd1;
      end
   endtask

   task automatic set_hv(input int h, input int v);
      h_cnt = 10'(h);
      v_cnt = 10'(v);
   endtask

   logic [7:0] burst_exp [4];
   int n_ack, last;
   logic seen;

   initial begin
      burst_exp[0] = 8'h03; burst_exp[1] = 8'h0A; burst_exp[2] = 8'h11; burst_exp[3] = 8'h18;
      step();
      fill = 1'b0;
      repeat (2) step();
      chk("rst_ram_addr", 32'(O_RAM_ADDR), 32'h0);
      chk("rst_ack", 32'(O_CPU_ACK), 32'h0);
      chk("rst_chr_valid", 32'(O_CHR_VALID), 32'h0);
      rst = 1'b0;
      step();

      // Fetch at row 1, line 1, col 2
      set_hv(16, 57);
      step();
      chk("t1_addr", 32'(O_RAM_ADDR), 32'h052);
      repeat (2) step();
      chk("t1_code", 32'(O_CHR_CODE), 32'h41);
      chk("t1_line", 32'(O_CHR_LINE), 32'h1);
      chk("t1_valid", 32'(O_CHR_VALID), 32'h1);

      // Last cell of the window, then the edges beyond it
      set_hv(632, 439);
      step();
      chk("t2_addr", 32'(O_RAM_ADDR), 32'h7CF);
      repeat (2) step();
      chk("t2_code", 32'(O_CHR_CODE), 32'hAC);
      chk("t2_line", 32'(O_CHR_LINE), 32'hF);
      chk("t2_valid", 32'(O_CHR_VALID), 32'h1);
      repeat (8) step();
      chk("t2_valid_drop", 32'(O_CHR_VALID), 32'h0);
      set_hv(640, 100);
      step();
      chk("t2_h640_addr", 32'(O_RAM_ADDR), 32'h7CF);
      set_hv(8, 440);
      step();
      chk("t2_v440_addr", 32'(O_RAM_ADDR), 32'h7CF);
      repeat (2) step();
      chk("t2_v440_valid", 32'(O_CHR_VALID), 32'h0);

      // CPU write sampled at H=3, then readback
      set_hv(3, 100);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h5A;
      step();
      chk("t3_we", 32'(O_RAM_WE), 32'h1);
      chk("t3_addr", 32'(O_RAM_ADDR), 32'h123);
      chk("t3_wdata", 32'(O_RAM_WDATA), 32'h5A);
      step();
      chk("t3_we_pulse", 32'(O_RAM_WE), 32'h0);
      chk("t3_ack_early", 32'(O_CPU_ACK), 32'h0);
      step();
      chk("t3_ack", 32'(O_CPU_ACK), 32'h1);
      cpu_req = 1'b0;
      step();
      chk("t3_ack_pulse", 32'(O_CPU_ACK), 32'h0);
      cpu_req = 1'b1; cpu_we = 1'b0;
      repeat (3) step();
      chk("t3_rd_ack", 32'(O_CPU_ACK), 32'h1);
      chk("t3_rd_data", 32'(O_CPU_RDATA), 32'h5A);
      cpu_req = 1'b0;
      step();

      // Request first meets a display slot
      set_hv(8, 57);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
      step();
      chk("t4_disp_addr", 32'(O_RAM_ADDR), 32'h051);
      step();
      chk("t4_cpu_addr", 32'(O_RAM_ADDR), 32'h010);
      step();
      chk("t4_code", 32'(O_CHR_CODE), 32'h3A);
      chk("t4_ack_early", 32'(O_CPU_ACK), 32'h0);
      step();
      chk("t4_ack", 32'(O_CPU_ACK), 32'h1);
      chk("t4_rdata", 32'(O_CPU_RDATA), 32'h73);
      cpu_req = 1'b0;
      step();

      // Back-to-back reads with REQ held high
      set_hv(0, 0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h000;
      n_ack = 0; last = 0;
      for (int c = 0; c < 40 && n_ack < 4; c++) begin
         step();
         if (O_CPU_ACK) begin
            chk("t5_rdata", 32'(O_CPU_RDATA), 32'(burst_exp[n_ack]));
            if (n_ack > 0) chk("t5_gap", 32'(c - last), 32'd4);
            last = c;
            n_ack++;
            cpu_addr = cpu_addr + 12'd1;
         end
      end
      chk("t5_acks", 32'(n_ack), 32'd4);
      cpu_req = 1'b0;
      step();

      // Reset while in S_CPU1
      set_hv(3, 0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
      step();
      rst = 1'b1;
      #1;
      chk("t6_rst_addr", 32'(O_RAM_ADDR), 32'h0);
      chk("t6_rst_code", 32'(O_CHR_CODE), 32'h0);
      chk("t6_rst_ack", 32'(O_CPU_ACK), 32'h0);
      repeat (3) step();
      chk("t6_rst_hold_ack", 32'(O_CPU_ACK), 32'h0);
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         step();
         if (O_CPU_ACK) begin
            seen = 1'b1;
            chk("t6_rdata", 32'(O_CPU_RDATA), 32'h5A);
         end
      end
      chk("t6_ack_seen", 32'(seen), 32'h1);
      cpu_req = 1'b0;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vram_fetch_arbiter.md
Name: vram_fetch_arbiter

Overview:
- Shares the single-port text VRAM between the Z80 CPU bus and the character display fetch.
- Uses the H/V counters from the VGA timing generator (800x525, 25 MHz) to schedule one display fetch per 8-pixel character cell.
- 80x25 text, 8x16 cells, 640x400 active window placed vertically inside the 480-line frame.
- CPU accesses fill all remaining RAM cycles, using a REQ/ACK handshake.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_OFFSET, 40, first V_CNT of the text window.
- V_ACTIVE, 400, text window height in lines.
- COLS, 80, characters per row.
- CHAR_H, 16, lines per character row; must be a power of 2.
- VRAM_BASE, 12'h000, VRAM address of row 0, col 0.

Ports:
- I_CLK  in  1  25 MHz pixel clock.
- I_RST  in  1  reset.
- I_H_CNT  in  10  horizontal counter, 0..799.
- I_V_CNT  in  10  vertical counter, 0..524.
- I_CPU_REQ  in  1  CPU access request, level, held until ACK.
- I_CPU_WE  in  1  1 = write, 0 = read; valid with REQ.
- I_CPU_ADDR  in  12  VRAM address.
- I_CPU_WDATA  in  8  write data.
- O_CPU_ACK  out  1  one-cycle completion pulse.
- O_CPU_RDATA  out  8  read data, valid while ACK = 1.
- O_RAM_ADDR  out  12  VRAM address; RAM is synchronous, read data appears on the cycle after the address.
- O_RAM_WE  out  1  VRAM write strobe, one cycle.
- O_RAM_WDATA  out  8  VRAM write data.
- I_RAM_RDATA  in  8  VRAM read data.
- O_CHR_CODE  out  8  fetched character code.
- O_CHR_LINE  out  4  font line within the cell.
- O_CHR_VALID  out  1  1 = code/line belong to an active cell.

Interface note (already decided): one clock, I_CLK; reset I_RST is asynchronous, active-high.

Behaviour:
- Reset: all outputs 0; FSM in S_IDLE; display pipeline valid bits cleared.
  - Reset mid-access aborts the access with no ACK; the CPU re-requests.
- Display slot (DS) = edge where the sampled I_H_CNT[2:0]==0, I_H_CNT<H_ACTIVE, and V_OFFSET<=I_V_CNT<V_OFFSET+V_ACTIVE.
- Address arithmetic:
  - L = I_V_CNT-V_OFFSET; row = L/CHAR_H; line = L%CHAR_H; col = I_H_CNT[9:3].
  - addr = VRAM_BASE + row*80 + col, computed as row<<6 + row<<4 + col, truncated to 12 bits. Maximum is 1999 = 12'h7CF.
- Display pipeline (fixed latency, no stalls):
  - Edge E (DS): O_RAM_ADDR<=addr, O_RAM_WE<=0, stage-1 valid<=1, line captured.
  - E+1: stage-2 valid<=stage-1.
  - E+2: O_CHR_CODE<=I_RAM_RDATA, O_CHR_LINE<=line, O_CHR_VALID<=1.
  - At phase-2 edges whose phase-0 slot was not DS: O_CHR_VALID<=0, code and line held.
  - Net effect: the cell c code is valid from H_CNT=8c+3 to 8c+10. The pixel stage compensates by delaying output one cell.
- CPU FSM, states S_IDLE -> S_CPU1 -> S_CPU2 -> S_ACK -> S_IDLE:
  - S_IDLE, REQ=1, not DS: drive O_RAM_ADDR/O_RAM_WE/O_RAM_WDATA from the CPU inputs; go to S_CPU1.
  - S_IDLE, REQ=1, DS: display wins; stay in S_IDLE and retry next edge.
  - S_CPU1 -> S_CPU2: O_RAM_WE<=0.
  - S_CPU2: O_CPU_RDATA<=I_RAM_RDATA (read) or held (write); O_CPU_ACK<=1; go to S_ACK.
  - S_ACK: O_CPU_ACK<=0; REQ is ignored at this edge; go to S_IDLE.
- Throughput and latency:
  - DS and CPU pipelines overlap; the RAM accepts one address per cycle.
  - REQ-to-ACK is 3 edges, 4 if the request meets a DS.
  - Maximum CPU rate is 1 access per 4 cycles.
- Non-DS, non-grant edges: O_RAM_WE<=0; O_RAM_ADDR and O_RAM_WDATA hold.
- Signals do not need to be stable while REQ=0. I_CPU_WE, I_CPU_ADDR and I_CPU_WDATA must be stable from REQ rise until ACK.
- Wrap-around: no fetch for V_CNT>=440, V_CNT<40, or H_CNT>=640. The last fetch is at H_CNT=632, V_CNT=439.

Decomposition:
- Shared package pc8001_video_pkg:
  - geometry constants: H_ACTIVE, V_OFFSET, V_ACTIVE, COLS, CHAR_H, HMAX=800, VMAX=525;
  - FSM state encoding for S_IDLE/S_CPU1/S_CPU2/S_ACK.
- One sub-module, vram_addr_gen: combinational; H/V count in, active flag plus 12-bit address plus 4-bit line out.

Test Plan:
- V_CNT=57, H_CNT=16 (row 1, line 1, col 2) -> O_RAM_ADDR=12'h052 after that edge; O_CHR_CODE = RAM[0x052], O_CHR_LINE=1, O_CHR_VALID=1 two edges later.
- V_CNT=439, H_CNT=632 -> addr 12'h7CF, line 15. V_CNT=440 -> no DS and O_CHR_VALID drops to 0. H_CNT=640 -> no fetch.
- CPU write 0x5A to 0x123, REQ sampled at H_CNT=3 -> O_RAM_WE=1 for exactly one cycle with addr 0x123 and data 0x5A; ACK 3 edges after the sample; a readback returns 0x5A with ACK.
- CPU REQ first sampled at an active H_CNT=8 (DS) -> display address is driven first; CPU grant at the next edge; ACK 4 edges after the first sample; display code is unaffected.
- REQ held high continuously for reads of 0x000..0x003 (address changed after each ACK) -> exactly one ACK every 4 cycles; no double grant on the ACK edge.
- I_RST asserted in S_CPU1 -> outputs zero immediately (asynchronous); no ACK; after release the same REQ completes normally.
